result_serializer: RTL and testbench

- Sits between the 3x3 multiplier result bus and the UART transmitter.
- On a start pulse, snapshots the 144-bit result (nine 16-bit elements) and emits it as 18 bytes through the uart_tx start/busy handshake, element R00 first, high byte first.
- Drives the control unit's SEND_RESULT phase and reports completion with a one-cycle done pulse.

---
 rtl/result_serializer.sv | 127 ++++++++++++
 tb/tb_result_serializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Serializes a snapshot of the packed 3x3 multiplier result into bytes for uart_tx.
// Element R00 goes first and each element is sent high byte first, using the tx_start/tx_busy handshake.
module result_serializer #(
  parameter int NUM_ELEMS    = 9,
  parameter int ELEM_W       = 16,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                        bclk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_ELEMS*ELEM_W-1:0] result,
  input  logic                        tx_busy,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  output logic                        busy,
  output logic                        done,
  output logic [4:0]                  byte_idx
);

  localparam int TOTAL_W   = NUM_ELEMS * ELEM_W;
  localparam int BPE       = ELEM_W / 8;
  localparam int NUM_BYTES = TOTAL_W / 8;
  localparam int CNT_W     = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [4:0]       LAST_IDX = 5'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FREE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t             state, state_nxt;
  logic [TOTAL_W-1:0] snapshot;
  logic [CNT_W-1:0]   to_cnt;
  logic [7:0]         byte_arr [NUM_BYTES];

  logic snap_load, idx_clr, idx_inc, data_load, cnt_clr, cnt_inc;

  // Byte i is taken from element i/BPE, with the most significant byte first.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_bytes
    localparam int E = i / BPE;
    localparam int S = i % BPE;
    assign byte_arr[i] = snapshot[E*ELEM_W + (BPE-1-S)*8 +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    data_load = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          idx_clr   = 1'b1;
          state_nxt = S_WAIT_FREE;
        end
      end
      S_WAIT_FREE: begin
        if (!tx_busy) begin
          data_load = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_clr   = 1'b1;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy)                state_nxt = S_WAIT_DONE;
        else if (to_cnt == TO_LAST) state_nxt = S_WAIT_FREE;
        else                        cnt_inc   = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = S_FINISH;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = S_WAIT_FREE;
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the wide snapshot register is reset so that no stale result can be sent after a reset.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      snapshot <= '0;
      byte_idx <= '0;
      tx_data  <= '0;
      to_cnt   <= '0;
    end else begin
      if (snap_load) snapshot <= result;
      if (idx_clr)        byte_idx <= '0;
      else if (idx_inc)   byte_idx <= byte_idx + 5'd1;
      if (data_load) tx_data <= byte_arr[byte_idx];
      if (cnt_clr)        to_cnt <= '0;
      else if (cnt_inc)   to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // The handshake outputs decode only the state register, so no input reaches an output combinationally.
  assign tx_start = (state == S_ISSUE);
  assign done     = (state == S_FINISH);
  assign busy     = (state == S_WAIT_FREE) || (state == S_ISSUE) ||
                    (state == S_WAIT_ACK)  || (state == S_WAIT_DONE);

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer.
// A uart_tx model stays busy for 10 cycles after each tx_start. The bench logs every pulse and compares it with hand-derived bytes.
module tb_result_serializer;

  logic         bclk = 1'b0;
  logic         rst;
  logic         start;
  logic [143:0] result;
  logic         tx_busy;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         busy;
  logic         done;
  logic [4:0]   byte_idx;

  int errors = 0;
  int checks = 0;

  result_serializer #(.NUM_ELEMS(9), .ELEM_W(16), .BUSY_TIMEOUT(255)) dut (
    .bclk     (bclk),
    .rst      (rst),
    .start    (start),
    .result   (result),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .done     (done),
    .byte_idx (byte_idx)
  );

  always #5 bclk = ~bclk;

  int         cyc        = 0;
  int         model_cnt  = 0;
  int         drop_at    = -1;
  bit         force_busy = 1'b0;
  int         done_total = 0;
  logic [7:0] log_data [$];
  logic [4:0] log_idx  [$];
  int         log_cyc  [$];

  assign tx_busy = force_busy || (model_cnt != 0);

  // The model ignores the pulse whose sequence number equals drop_at.
  always @(posedge bclk) begin
    if (tx_start && (log_data.size() != drop_at)) model_cnt <= 10;
    else if (model_cnt != 0)                      model_cnt <= model_cnt - 1;
    if (tx_start) begin
      log_data.push_back(tx_data);
      log_idx.push_back(byte_idx);
      log_cyc.push_back(cyc);
    end
    if (done) done_total <= done_total + 1;
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] pat_a();
    logic [143:0] r;
    for (int k = 0; k < 9; k++) r[16*k +: 16] = 16'(16'h0102 * (k + 1));
    return r;
  endfunction

  function automatic logic [143:0] pat_b();
    logic [143:0] r;
    for (int k = 0; k < 9; k++) r[16*k +: 16] = {8'(8'hA0 + k), 8'(8'h50 + k)};
    return r;
  endfunction

  function automatic logic [7:0] exp_a(input int i);
    logic [15:0] v;
    v = 16'(16'h0102 * (i / 2 + 1));
    return (i % 2 == 0) ? v[15:8] : v[7:0];
  endfunction

  function automatic logic [7:0] exp_b(input int i);
    return (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'(8'h50 + i / 2);
  endfunction

  task automatic launch(input logic [143:0] r, output int sc);
    result = r;
    start  = 1'b1;
    sc     = cyc;
    @(negedge bclk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget && !done; i++) @(negedge bclk);
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_idx(input logic [4:0] v, input int budget, input string tag);
    for (int i = 0; i < budget && byte_idx != v; i++) @(negedge bclk);
    check(tag, 32'(byte_idx), 32'(v));
  endtask

  task automatic check_bytes(input int base, input bit use_b, input string tag);
    check({tag, " count"}, 32'(log_data.size() - base), 32'd18);
    if (log_data.size() - base == 18)
      for (int i = 0; i < 18; i++)
        check($sformatf("%s byte%0d", tag, i), 32'(log_data[base + i]),
              32'(use_b ? exp_b(i) : exp_a(i)));
  endtask

  initial begin
    int base, dbase, sc, rel, pc;
    rst    = 1'b1;
    start  = 1'b0;
    result = '0;
    repeat (3) @(negedge bclk);
    check("rst tx_data", 32'(tx_data), 32'h0);
    check("rst tx_start", 32'(tx_start), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst byte_idx", 32'(byte_idx), 32'h0);
    rst = 1'b0;
    @(negedge bclk);

    // Basic send
    base = log_data.size(); dbase = done_total;
    launch(pat_a(), sc);
    check("basic busy", 32'(busy), 32'd1);
    wait_done(1000, "basic done");
    @(negedge bclk);
    check("basic busy after", 32'(busy), 32'd0);
    check("basic idx hold", 32'(byte_idx), 32'd17);
    repeat (3) @(negedge bclk);
    check_bytes(base, 1'b0, "basic");
    if (log_cyc.size() > base) check("basic latency", 32'(log_cyc[base] - sc), 32'd2);
    check("basic done pulses", 32'(done_total - dbase), 32'd1);

    // Snapshot: result changes right after start and again mid-transfer
    base = log_data.size();
    launch(pat_b(), sc);
    result = pat_a();
    repeat (100) @(negedge bclk);
    result = '1;
    wait_done(1000, "snap done");
    repeat (2) @(negedge bclk);
    check_bytes(base, 1'b1, "snap");

    // Pre-busy: uart busy when start is accepted
    force_busy = 1'b1;
    @(negedge bclk);
    base = log_data.size();
    launch(pat_a(), sc);
    repeat (19) @(negedge bclk);
    check("prebusy no early", 32'(log_data.size() - base), 32'd0);
    force_busy = 1'b0;
    rel = cyc;
    wait_done(1000, "prebusy done");
    repeat (2) @(negedge bclk);
    check_bytes(base, 1'b0, "prebusy");
    if (log_cyc.size() > base) begin
      check("prebusy first cyc", 32'(log_cyc[base]), 32'(rel + 1));
      check("prebusy first idx", 32'(log_idx[base]), 32'd0);
      check("prebusy first data", 32'(log_data[base]), 32'h01);
    end

    // Timeout: the first pulse for byte 5 is ignored by the model
    base = log_data.size(); dbase = done_total;
    drop_at = base + 5;
    launch(pat_a(), sc);
    wait_done(2000, "timeout done");
    drop_at = -1;
    repeat (2) @(negedge bclk);
    check("timeout count", 32'(log_data.size() - base), 32'd19);
    check("timeout done pulses", 32'(done_total - dbase), 32'd1);
    if (log_data.size() - base == 19) begin
      for (int i = 0; i < 19; i++)
        check($sformatf("timeout pulse%0d", i), 32'(log_data[base + i]),
              32'(exp_a(i <= 5 ? i : i - 1)));
      check("timeout retry idx", 32'(log_idx[base + 6]), 32'd5);
      // The retry follows ISSUE, then 255 WAIT_ACK cycles, then WAIT_FREE.
      check("timeout gap", 32'(log_cyc[base + 6] - log_cyc[base + 5]), 32'd257);
    end

    // Start collision: mid-transfer and in the done cycle
    base = log_data.size();
    launch(pat_a(), sc);
    wait_idx(5'd7, 500, "coll reach idx7");
    result = pat_b();
    start  = 1'b1;
    @(negedge bclk);
    start  = 1'b0;
    check("coll busy", 32'(busy), 32'd1);
    check("coll idx", 32'(byte_idx), 32'd7);
    wait_done(1000, "coll done");
    start = 1'b1;
    @(negedge bclk);
    start = 1'b0;
    check("coll done-cycle busy", 32'(busy), 32'd0);
    check("coll done low", 32'(done), 32'd0);
    check_bytes(base, 1'b0, "coll");
    base = log_data.size();
    launch(pat_b(), sc);
    check("fresh busy", 32'(busy), 32'd1);
    wait_done(1000, "fresh done");
    repeat (2) @(negedge bclk);
    check_bytes(base, 1'b1, "fresh");

    // Reset mid-transfer
    launch(pat_a(), sc);
    wait_idx(5'd3, 300, "rstmid reach idx3");
    rst = 1'b1;
    #1;
    check("rstmid tx_data", 32'(tx_data), 32'h0);
    check("rstmid tx_start", 32'(tx_start), 32'h0);
    check("rstmid busy", 32'(busy), 32'h0);
    check("rstmid done", 32'(done), 32'h0);
    check("rstmid byte_idx", 32'(byte_idx), 32'h0);
    repeat (3) @(negedge bclk);
    rst = 1'b0;
    pc = log_data.size();
    repeat (300) @(negedge bclk);
    check("rstmid no tx_start", 32'(log_data.size() - pc), 32'd0);
    check("rstmid idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
